branch_perf_counters: RTL and testbench
=======================================

# branch_perf_counters

Parametrised multi-channel event counter bank for pipeline performance monitoring, e.g. branch lookups, mispredictions and flushes. It generalises the single 16-bit misprediction counter into CHANNELS independent counters of configurable width. A programmable sampling window periodically snapshots and restarts the live counts, and per-channel sticky overflow flags are provided. It sits beside the branch predictor and hazard unit and is observed by the testbench or a debug read port.

## Interface

Parameters:
- WIDTH, 16, bit width of every live and snapshot counter (≥2)
- CHANNELS, 2, number of independent event channels (≥1)
- WINDOW, 256, enabled cycles per sampling window (≥2)

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge
- INIT  in  1  asynchronous, active-high reset
- CLEAR  in  1  synchronous clear of live counters, window position and OVF
- ENABLE  in  1  count gate; events and window advance only when high
- EVENT  in  CHANNELS  bit i = one event on channel i this cycle
- SEL  in  max(1,$clog2(CHANNELS))  channel select for read-out muxes
- LIVE_COUNT  out  WIDTH  live counter of channel SEL
- SNAP_COUNT  out  WIDTH  last window snapshot of channel SEL
- SNAP_VALID  out  1  one-cycle pulse: new snapshot available
- OVF  out  CHANNELS  sticky per-channel overflow flags
- WINDOW_POS  out  $clog2(WINDOW)  enabled cycles elapsed in current window

## Operation

- State: cnt[i], snap[i] (WIDTH each), wpos, SNAP_VALID register, OVF register.
- Priority per edge: INIT > CLEAR > window end > normal count.
- INIT asserted: all state cleared to 0 immediately, without waiting for a clock edge. All outputs read 0 while INIT is high.
- CLEAR (sync):
  - cnt, wpos and OVF go to 0; SNAP_VALID goes to 0.
  - snap is retained.
  - EVENT that cycle is discarded.
- ENABLE low, CLEAR low: all state holds. SNAP_VALID goes to 0.
- ENABLE high, wpos < WINDOW-1:
  - wpos increments.
  - cnt[i] = inc(cnt[i], EVENT[i]).
  - SNAP_VALID goes to 0.
- ENABLE high, wpos == WINDOW-1 (window end):
  - snap[i] = inc(cnt[i], EVENT[i]), so the last cycle's event is included.
  - cnt[i] and wpos go to 0.
  - SNAP_VALID goes to 1.
- inc(c,e): returns c if e=0, otherwise c+1 computed at WIDTH bits. Overflow is c = all-ones with e=1; the result then follows the Configuration rule, and OVF[i] is set.
- OVF bits are sticky. Only INIT or CLEAR clears them; a window end does not.
- Multiple channels may fire in the same cycle. Each channel counts independently.
- LIVE_COUNT and SNAP_COUNT are combinational muxes of the registered cnt[SEL] and snap[SEL].
- SEL ≥ CHANNELS: both read-out muxes output 0.

## Timing

- Event-to-LIVE_COUNT latency: 1 cycle. An event sampled at edge k is visible after edge k.
- SNAP_VALID:
  - High for exactly the one cycle following the window-end edge.
  - Consecutive pulses are at least WINDOW enabled cycles apart.
- snap updates on the same edge that raises SNAP_VALID. It stays stable until the next window end.
- CLEAR on a window-end cycle: clear wins, no snapshot is taken, and SNAP_VALID stays 0.
- INIT asserted mid-window: the window restarts at wpos=0 after release.
- The first enabled edge after INIT release counts normally.

## Configuration

- Macro: PERF_SATURATE_EN.
- Defined: on overflow the counter saturates and holds all-ones; OVF[i] is set.
- Undefined (default): on overflow the counter wraps to 0; OVF[i] is set.
- The same rule applies to the value written into snap at a window end.

## Test plan

- Reset:
  - Stimulus: WIDTH=16, CHANNELS=2, WINDOW=8; count 3 events on ch0, then pulse INIT asynchronously between edges.
  - Required: LIVE_COUNT, SNAP_COUNT, OVF and WINDOW_POS read 0 immediately, with SNAP_VALID=0.
- Basic count:
  - Stimulus: EVENT[0] sequence 0,0,1,0,1,1,0 with ENABLE=1, SEL=0.
  - Required: LIVE_COUNT=3 and WINDOW_POS=7 one cycle after the last event.
- Window snapshot:
  - Stimulus: EVENT=2'b10 for 8 enabled cycles, SEL=1.
  - Required: SNAP_VALID high for 1 cycle, SNAP_COUNT=8, LIVE_COUNT=0 and WINDOW_POS=0 in that same cycle; SNAP_COUNT for SEL=0 is 0.
- ENABLE gating:
  - Stimulus: ENABLE=0 for 5 cycles with EVENT=2'b11.
  - Required: LIVE_COUNT and WINDOW_POS unchanged and no SNAP_VALID; the window end is delayed by exactly 5 cycles.
- Overflow:
  - Stimulus: WIDTH=4, 17 events on ch0 within one window (WINDOW=32).
  - Required: default build gives LIVE_COUNT=1 with OVF[0]=1; PERF_SATURATE_EN build gives LIVE_COUNT=15 with OVF[0]=1.
  - Required: OVF[1]=0 in both builds.
- CLEAR collision:
  - Stimulus: assert CLEAR on the window-end cycle after a prior snapshot of 5.
  - Required: no SNAP_VALID; SNAP_COUNT stays 5; LIVE_COUNT=0, WINDOW_POS=0 and OVF=0.

Source files
------------

// File: rtl/branch_perf_counters.sv
// branch_perf_counters
//
// A bank of CHANNELS independent WIDTH-bit event counters for pipeline performance monitoring
// (branch lookups, mispredictions, flushes, ...). A sampling window of WINDOW enabled cycles
// periodically copies the live counts into a snapshot bank and restarts them. Each channel
// also has a sticky overflow flag.
//
// Build option:
//   PERF_SATURATE_EN  defined   -> a counter that overflows saturates at all-ones
//                     undefined -> a counter that overflows wraps to zero (default)
//   OVF is set in both builds. The same rule applies to the value captured at a window end.
//
// Ports:
//   clock_i        single clock; all state updates on the rising edge
//   init_i         asynchronous active-high reset; every output reads 0 while it is high
//   clear_i        synchronous clear of live counters, window position and overflow flags
//   enable_i       count gate; events and window advance only while high
//   event_i        bit i = one event on channel i this cycle
//   sel_i          channel select for the two read-out muxes (out of range reads 0)
//   live_count_o   live counter of channel sel_i
//   snap_count_o   last window snapshot of channel sel_i
//   snap_valid_o   one-cycle pulse following the window-end edge
//   ovf_o          sticky per-channel overflow flags
//   window_pos_o   enabled cycles elapsed in the current window
module branch_perf_counters #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WINDOW   = 256,
  localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PosW    = $clog2(WINDOW)
) (
  input  logic                clock_i,
  input  logic                init_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [CHANNELS-1:0] event_i,
  input  logic [SelW-1:0]     sel_i,
  output logic [WIDTH-1:0]    live_count_o,
  output logic [WIDTH-1:0]    snap_count_o,
  output logic                snap_valid_o,
  output logic [CHANNELS-1:0] ovf_o,
  output logic [PosW-1:0]     window_pos_o
);

  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    cnt_d  [CHANNELS];
  logic [WIDTH-1:0]    snap_q [CHANNELS];
  logic [WIDTH-1:0]    snap_d [CHANNELS];
  logic [PosW-1:0]     wpos_q, wpos_d;
  logic                snap_valid_q, snap_valid_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  // Per-channel incremented value and its overflow condition, shared by the normal-count
  // path and the window-end snapshot path so the last cycle's event lands in the snapshot.
  logic [WIDTH-1:0]    inc_val [CHANNELS];
  logic [CHANNELS-1:0] inc_ovf;
  logic                win_end;

  assign win_end = (wpos_q == PosW'(WINDOW - 1));

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      inc_ovf[i] = event_i[i] & (&cnt_q[i]);
      if (!event_i[i]) begin
        inc_val[i] = cnt_q[i];
      end else if (inc_ovf[i]) begin
`ifdef PERF_SATURATE_EN
        inc_val[i] = '1;
`else
        inc_val[i] = '0;
`endif
      end else begin
        inc_val[i] = cnt_q[i] + WIDTH'(1);
      end
    end
  end

  // Priority: clear > window end > normal count. The pulse drops on every edge unless
  // this edge ends a window.
  always_comb begin
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    wpos_d       = wpos_q;
    ovf_d        = ovf_q;
    snap_valid_d = 1'b0;

    if (clear_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_d[i] = '0;
      end
      wpos_d = '0;
      ovf_d  = '0;
    end else if (enable_i) begin
      ovf_d = ovf_q | inc_ovf;
      if (win_end) begin
        snap_d = inc_val;
        for (int i = 0; i < CHANNELS; i++) begin
          cnt_d[i] = '0;
        end
        wpos_d       = '0;
        snap_valid_d = 1'b1;
      end else begin
        cnt_d  = inc_val;
        wpos_d = wpos_q + PosW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or posedge init_i) begin
    if (init_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      wpos_q       <= '0;
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      wpos_q       <= wpos_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Loop-compare read-out so an unused select code simply matches nothing and reads 0.
  always_comb begin
    live_count_o = '0;
    snap_count_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SelW'(i) == sel_i) begin
        live_count_o = cnt_q[i];
        snap_count_o = snap_q[i];
      end
    end
  end

  assign snap_valid_o = snap_valid_q;
  assign ovf_o        = ovf_q;
  assign window_pos_o = wpos_q;

endmodule

// File: tb/tb_branch_perf_counters.sv
module tb_branch_perf_counters;

`ifdef PERF_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic init;
  always #5 clk = ~clk;

  // Instance A: WIDTH=16, CHANNELS=2, WINDOW=8
  logic        clear_a, en_a, sel_a, sv_a;
  logic [1:0]  ev_a, ovf_a;
  logic [15:0] live_a, snap_a;
  logic [2:0]  wpos_a;

  // Instance B: WIDTH=4, CHANNELS=2, WINDOW=32
  logic        clear_b, en_b, sel_b, sv_b;
  logic [1:0]  ev_b, ovf_b;
  logic [3:0]  live_b, snap_b;
  logic [4:0]  wpos_b;

  branch_perf_counters #(.WIDTH(16), .CHANNELS(2), .WINDOW(8)) dut_a (
    .clock_i(clk), .init_i(init), .clear_i(clear_a), .enable_i(en_a), .event_i(ev_a),
    .sel_i(sel_a), .live_count_o(live_a), .snap_count_o(snap_a), .snap_valid_o(sv_a),
    .ovf_o(ovf_a), .window_pos_o(wpos_a)
  );

  branch_perf_counters #(.WIDTH(4), .CHANNELS(2), .WINDOW(32)) dut_b (
    .clock_i(clk), .init_i(init), .clear_i(clear_b), .enable_i(en_b), .event_i(ev_b),
    .sel_i(sel_b), .live_count_o(live_b), .snap_count_o(snap_b), .snap_valid_o(sv_b),
    .ovf_o(ovf_b), .window_pos_o(wpos_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserted between edges; checked while still high, released before the next edge.
  task automatic pulse_init(input string tag);
    #2 init = 1'b1;
    #1;
    check({tag, " live"}, live_a, 0);
    check({tag, " snap"}, snap_a, 0);
    check({tag, " ovf"}, ovf_a, 0);
    check({tag, " wpos"}, wpos_a, 0);
    check({tag, " sv"}, sv_a, 0);
    #1 init = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int        mcnt [2][2];
  int        msnap[2][2];
  int        mpos [2];
  int        mwin [2];
  int        mmax [2];
  logic [1:0] movf[2];
  logic      msv  [2];

  function automatic void mreset(input int k);
    for (int c = 0; c < 2; c++) begin
      mcnt[k][c]  = 0;
      msnap[k][c] = 0;
    end
    mpos[k] = 0;
    movf[k] = 2'b00;
    msv[k]  = 1'b0;
  endfunction

  function automatic void mstep(input int k, input logic clr, input logic en,
                                input logic [1:0] ev);
    int nxt[2];
    msv[k] = 1'b0;
    if (clr) begin
      mcnt[k][0] = 0;
      mcnt[k][1] = 0;
      mpos[k]    = 0;
      movf[k]    = 2'b00;
      return;
    end
    if (!en) return;
    for (int c = 0; c < 2; c++) begin
      nxt[c] = mcnt[k][c] + (ev[c] ? 1 : 0);
      if (nxt[c] > mmax[k]) begin
        movf[k][c] = 1'b1;
        nxt[c] = Sat ? mmax[k] : 0;
      end
    end
    if (mpos[k] == mwin[k] - 1) begin
      msnap[k][0] = nxt[0];
      msnap[k][1] = nxt[1];
      mcnt[k][0]  = 0;
      mcnt[k][1]  = 0;
      mpos[k]     = 0;
      msv[k]      = 1'b1;
    end else begin
      mcnt[k][0] = nxt[0];
      mcnt[k][1] = nxt[1];
      mpos[k]++;
    end
  endfunction

  task automatic cmp_model(input int k, input int cyc);
    longint al, as, av, ao, aw;
    int s;
    if (k == 0) begin
      al = live_a; as = snap_a; av = sv_a; ao = ovf_a; aw = wpos_a; s = sel_a;
    end else begin
      al = live_b; as = snap_b; av = sv_b; ao = ovf_b; aw = wpos_b; s = sel_b;
    end
    check($sformatf("rnd%0d c%0d live", k, cyc), al, mcnt[k][s]);
    check($sformatf("rnd%0d c%0d snap", k, cyc), as, msnap[k][s]);
    check($sformatf("rnd%0d c%0d sv", k, cyc), av, msv[k]);
    check($sformatf("rnd%0d c%0d ovf", k, cyc), ao, movf[k]);
    check($sformatf("rnd%0d c%0d wpos", k, cyc), aw, mpos[k]);
  endtask

  // ---------------- directed vector tables (instance A) ----------------
  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] ev;
    logic       sel;
    int         live;
    int         snap;
    logic       sv;
    int         wpos;
  } vec_t;

  vec_t va[11];
  vec_t vb[8];

  function automatic vec_t mk(input logic clr, input logic en, input logic [1:0] ev,
                              input logic sel, input int live, input int snap,
                              input logic sv, input int wpos);
    vec_t v;
    v.clr = clr; v.en = en; v.ev = ev; v.sel = sel;
    v.live = live; v.snap = snap; v.sv = sv; v.wpos = wpos;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    clear_a = v.clr; en_a = v.en; ev_a = v.ev; sel_a = v.sel;
    tick();
    check({tag, " live"}, live_a, v.live);
    check({tag, " snap"}, snap_a, v.snap);
    check({tag, " sv"}, sv_a, v.sv);
    check({tag, " wpos"}, wpos_a, v.wpos);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int since;
    bit found;
    int exp_b;

    // Basic count on ch0 (ch1 events must not leak), then a window end and 3 more events.
    va[0]  = mk(0, 1, 2'b10, 0, 0, 0, 0, 1);
    va[1]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 2);
    va[2]  = mk(0, 1, 2'b01, 0, 1, 0, 0, 3);
    va[3]  = mk(0, 1, 2'b10, 0, 1, 0, 0, 4);
    va[4]  = mk(0, 1, 2'b01, 0, 2, 0, 0, 5);
    va[5]  = mk(0, 1, 2'b01, 0, 3, 0, 0, 6);
    va[6]  = mk(0, 1, 2'b00, 0, 3, 0, 0, 7);
    va[7]  = mk(0, 1, 2'b00, 0, 0, 3, 1, 0);
    va[8]  = mk(0, 1, 2'b01, 0, 1, 3, 0, 1);
    va[9]  = mk(0, 1, 2'b01, 0, 2, 3, 0, 2);
    va[10] = mk(0, 1, 2'b01, 0, 3, 3, 0, 3);
    // Window snapshot on ch1: 8 events, pulse on the 8th edge.
    for (int i = 0; i < 7; i++) vb[i] = mk(0, 1, 2'b10, 1, i + 1, 0, 0, i + 1);
    vb[7] = mk(0, 1, 2'b10, 1, 0, 8, 1, 0);

    init = 1'b1;
    clear_a = 0; en_a = 0; ev_a = 0; sel_a = 0;
    clear_b = 0; en_b = 0; ev_b = 0; sel_b = 0;
    mwin[0] = 8;  mmax[0] = 16'hFFFF;
    mwin[1] = 32; mmax[1] = 15;

    #1;
    check("reset live", live_a, 0);
    check("reset snap", snap_a, 0);
    check("reset sv", sv_a, 0);
    check("reset ovf", ovf_a, 0);
    check("reset wpos", wpos_a, 0);
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    tick();
    en_a = 1'b0;

    for (int i = 0; i < 11; i++) apply_vec(va[i], $sformatf("tabA[%0d]", i));

    // Asynchronous reset mid-cycle clears snapshot and live count immediately.
    pulse_init("async init");

    for (int i = 0; i < 8; i++) apply_vec(vb[i], $sformatf("tabB[%0d]", i));
    sel_a = 1'b0;
    #1;
    check("win snap ch0", snap_a, 0);
    sel_a = 1'b1;

    // ENABLE gating delays the window end by exactly the number of disabled cycles.
    since = 0;
    ev_a = 2'b11; en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); since++; end
    check("gate pre live", live_a, 3);
    check("gate pre wpos", wpos_a, 3);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); since++;
      check($sformatf("gate[%0d] live", i), live_a, 3);
      check($sformatf("gate[%0d] wpos", i), wpos_a, 3);
      check($sformatf("gate[%0d] sv", i), sv_a, 0);
    end
    en_a = 1'b1; ev_a = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); since++;
      if (sv_a) found = 1'b1;
    end
    check("gate pulse seen", found, 1);
    check("gate pulse spacing", since, 13);
    check("gate snap ch1", snap_a, 3);

    // CLEAR on a window-end cycle after a snapshot of 5.
    pulse_init("init2");
    sel_a = 1'b0; en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ev_a = (i < 5) ? 2'b01 : 2'b00;
      tick();
    end
    check("clr prior sv", sv_a, 1);
    check("clr prior snap", snap_a, 5);
    ev_a = 2'b01;
    for (int i = 0; i < 7; i++) tick();
    check("clr pre wpos", wpos_a, 7);
    clear_a = 1'b1; ev_a = 2'b11;
    tick();
    check("clr sv", sv_a, 0);
    check("clr snap", snap_a, 5);
    check("clr live", live_a, 0);
    check("clr wpos", wpos_a, 0);
    check("clr ovf", ovf_a, 0);
    clear_a = 1'b0; en_a = 1'b0;
    tick();
    check("clr after sv", sv_a, 0);
    check("clr after snap", snap_a, 5);

    // Overflow on the 4-bit instance.
    sel_b = 1'b0; en_b = 1'b1; ev_b = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    check("ovf15 live", live_b, 15);
    check("ovf15 ovf", ovf_b, 0);
    tick(); tick();
    exp_b = Sat ? 15 : 1;
    check("ovf17 live", live_b, exp_b);
    check("ovf17 ovf0", ovf_b[0], 1);
    check("ovf17 ovf1", ovf_b[1], 0);
    check("ovf17 wpos", wpos_b, 17);
    ev_b = 2'b00;
    for (int i = 0; i < 14; i++) tick();
    check("ovf pre-end wpos", wpos_b, 31);
    tick();
    check("ovf end sv", sv_b, 1);
    check("ovf end snap", snap_b, exp_b);
    check("ovf sticky", ovf_b, 2'b01);
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    check("ovf cleared", ovf_b, 0);
    check("ovf snap kept", snap_b, exp_b);

    // Randomized run against the reference model, same stimulus to both instances.
    pulse_init("init3");
    mreset(0);
    mreset(1);
    for (int c = 0; c < 600; c++) begin
      logic       r_clr, r_en, r_sel;
      logic [1:0] r_ev;
      r_clr = ($urandom_range(0, 24) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_ev  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      r_sel = 1'($urandom);
      clear_a = r_clr; en_a = r_en; ev_a = r_ev; sel_a = r_sel;
      clear_b = r_clr; en_b = r_en; ev_b = r_ev; sel_b = r_sel;
      tick();
      mstep(0, r_clr, r_en, r_ev);
      mstep(1, r_clr, r_en, r_ev);
      cmp_model(0, c);
      cmp_model(1, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
